// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- result broadcast stage between the functional units and the
// common data bus.
//
// Each FU pushes completed results into a private FIFO. A rotating-priority
// arbiter picks up to CDB_WIDTH non-empty FIFO heads per cycle, in scan order
// starting at the priority pointer. The picked heads pop, and their payloads
// land in registered CDB lanes for one cycle.
//
// Ports:
//   clk                      clock, all state on rising edge
//   rst                      synchronous active-low reset
//   flush                    discards every buffered and outgoing result
//   fu_valid / fu_ready      per-FU enqueue handshake
//   fu_rob_id/pd/rd/data     packed per-FU result payload, FU i at slice i
//   cdb_valid                per-lane broadcast valid, one cycle per result
//   cdb_rob_id/pd/rd/data    packed per-lane registered payload
module cdb_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int CDB_WIDTH  = 2,
    parameter int BUF_DEPTH  = 2,
    parameter int ROB_IDX_W  = 5,
    parameter int PRF_IDX_W  = 6,
    parameter int ARCH_IDX_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [NUM_FU-1:0]               fu_valid,
    output logic [NUM_FU-1:0]               fu_ready,
    input  logic [NUM_FU*ROB_IDX_W-1:0]     fu_rob_id,
    input  logic [NUM_FU*PRF_IDX_W-1:0]     fu_pd,
    input  logic [NUM_FU*ARCH_IDX_W-1:0]    fu_rd,
    input  logic [NUM_FU*DATA_W-1:0]        fu_data,
    output logic [CDB_WIDTH-1:0]            cdb_valid,
    output logic [CDB_WIDTH*ROB_IDX_W-1:0]  cdb_rob_id,
    output logic [CDB_WIDTH*PRF_IDX_W-1:0]  cdb_pd,
    output logic [CDB_WIDTH*ARCH_IDX_W-1:0] cdb_rd,
    output logic [CDB_WIDTH*DATA_W-1:0]     cdb_data
);

    // Payload is kept as one vector {rob_id, pd, rd, data}.
    localparam int PL_W  = ROB_IDX_W + PRF_IDX_W + ARCH_IDX_W + DATA_W;
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [FU_W-1:0]                  r_ptr;
    logic [CDB_WIDTH-1:0]             r_cdb_valid;
    logic [CDB_WIDTH-1:0][PL_W-1:0]   r_cdb_pl;

    logic [NUM_FU-1:0][PL_W-1:0]      w_fu_pl;
    logic [NUM_FU-1:0][PL_W-1:0]      w_head;
    logic [NUM_FU-1:0]                w_nonempty;
    logic [NUM_FU-1:0]                w_enq;
    logic [NUM_FU-1:0]                w_grant;
    logic [NUM_FU-1:0][FU_W-1:0]      w_scan;
    logic [CDB_WIDTH-1:0][FU_W-1:0]   w_lane_fu;
    logic [CDB_WIDTH-1:0]             w_lane_vld;
    logic [FU_W-1:0]                  w_next_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
            logic [PL_W-1:0]  r_mem [BUF_DEPTH];
            logic [PTR_W-1:0] r_rd_ptr;
            logic [PTR_W-1:0] r_wr_ptr;
            logic [CNT_W-1:0] r_count;

            assign w_fu_pl[gi]    = {fu_rob_id[gi*ROB_IDX_W +: ROB_IDX_W],
                                     fu_pd[gi*PRF_IDX_W +: PRF_IDX_W],
                                     fu_rd[gi*ARCH_IDX_W +: ARCH_IDX_W],
                                     fu_data[gi*DATA_W +: DATA_W]};
            assign w_nonempty[gi] = (r_count != '0);
            // Ready looks only at the registered count: a full FIFO stays
            // not-ready even on a cycle where its head is being popped.
            assign fu_ready[gi]   = (r_count != CNT_W'(BUF_DEPTH));
            assign w_enq[gi]      = fu_valid[gi] && fu_ready[gi];
            assign w_head[gi]     = r_mem[r_rd_ptr];
            // Scan slot gi holds FU (ptr + gi) mod NUM_FU.
            assign w_scan[gi]     = FU_W'((int'(r_ptr) + gi) % NUM_FU);

            always_ff @(posedge clk) begin
                if (!rst || flush) begin
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_enq[gi])
                        r_wr_ptr <= (r_wr_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
                    if (w_grant[gi])
                        r_rd_ptr <= (r_rd_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
                    r_count <= r_count + CNT_W'(w_enq[gi]) - CNT_W'(w_grant[gi]);
                end
            end

            // Storage needs no reset; the count alone defines what is live.
            always_ff @(posedge clk) begin
                if (rst && !flush && w_enq[gi])
                    r_mem[r_wr_ptr] <= w_fu_pl[gi];
            end
        end
    endgenerate

    // Walk the scan order, granting the first CDB_WIDTH non-empty FIFOs.
    // The n-th grant goes to lane n; the pointer moves past the last grant.
    always_comb begin
        int n;
        w_grant    = '0;
        w_lane_vld = '0;
        w_lane_fu  = '0;
        w_next_ptr = r_ptr;
        n          = 0;
        for (int j = 0; j < NUM_FU; j++) begin
            if (w_nonempty[w_scan[j]] && n < CDB_WIDTH) begin
                w_grant[w_scan[j]] = 1'b1;
                for (int k = 0; k < CDB_WIDTH; k++) begin
                    if (k == n) begin
                        w_lane_vld[k] = 1'b1;
                        w_lane_fu[k]  = w_scan[j];
                    end
                end
                w_next_ptr = (w_scan[j] == FU_W'(NUM_FU - 1)) ? '0 : w_scan[j] + 1'b1;
                n++;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr       <= '0;
            r_cdb_valid <= '0;
            r_cdb_pl    <= '0;
        end else if (flush) begin
            r_ptr       <= '0;
            r_cdb_valid <= '0;
        end else begin
            r_ptr       <= w_next_ptr;
            r_cdb_valid <= w_lane_vld;
            // Idle lanes hold their last payload.
            for (int k = 0; k < CDB_WIDTH; k++)
                if (w_lane_vld[k])
                    r_cdb_pl[k] <= w_head[w_lane_fu[k]];
        end
    end

    assign cdb_valid = r_cdb_valid;

    genvar gk;
    generate
        for (gk = 0; gk < CDB_WIDTH; gk++) begin : g_lane
            assign cdb_rob_id[gk*ROB_IDX_W +: ROB_IDX_W] = r_cdb_pl[gk][PL_W-1 -: ROB_IDX_W];
            assign cdb_pd[gk*PRF_IDX_W +: PRF_IDX_W]     = r_cdb_pl[gk][DATA_W+ARCH_IDX_W+PRF_IDX_W-1 -: PRF_IDX_W];
            assign cdb_rd[gk*ARCH_IDX_W +: ARCH_IDX_W]   = r_cdb_pl[gk][DATA_W+ARCH_IDX_W-1 -: ARCH_IDX_W];
            assign cdb_data[gk*DATA_W +: DATA_W]         = r_cdb_pl[gk][DATA_W-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (NUM_FU=4, CDB_WIDTH=2, BUF_DEPTH=2).
// Accepted results are pushed into per-FU queues; every valid CDB lane must
// match the head of one of those queues. Directed scenarios add exact
// cycle-by-cycle lane checks.
module tb_cdb_arbiter;
    localparam int NF = 4;
    localparam int CW = 2;
    localparam int BD = 2;

    logic         clk = 1'b0;
    logic         rst, flush;
    logic [3:0]   fu_valid, fu_ready;
    logic [19:0]  fu_rob_id;
    logic [23:0]  fu_pd;
    logic [19:0]  fu_rd;
    logic [127:0] fu_data;
    logic [1:0]   cdb_valid;
    logic [9:0]   cdb_rob_id;
    logic [11:0]  cdb_pd;
    logic [9:0]   cdb_rd;
    logic [63:0]  cdb_data;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .NUM_FU(NF), .CDB_WIDTH(CW), .BUF_DEPTH(BD),
        .ROB_IDX_W(5), .PRF_IDX_W(6), .ARCH_IDX_W(5), .DATA_W(32)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_rob_id(fu_rob_id), .fu_pd(fu_pd), .fu_rd(fu_rd), .fu_data(fu_data),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_pd(cdb_pd),
        .cdb_rd(cdb_rd), .cdb_data(cdb_data)
    );

    int  total = 0, bad = 0, seq = 1, cyc = 0;
    bit  mon_en = 1'b0, nr0_seen = 1'b0;
    logic [47:0] sbq [NF][$];
    int  bc_cnt [NF] = '{default: 0};
    int  acc_cyc[NF] = '{default: 0};
    int  bc_cyc3 = -1;

    always @(posedge clk) cyc++;

    // Unique per (FU, seq): pd[5:4] and data[31:24] carry the FU number.
    function automatic logic [47:0] pl(input int i, input int s);
        return {5'(s), 2'(i), 4'(s), 5'(i), 8'(i), 24'(s)};
    endfunction

    function automatic logic [47:0] lane_pl(input int k);
        return {cdb_rob_id[k*5 +: 5], cdb_pd[k*6 +: 6], cdb_rd[k*5 +: 5], cdb_data[k*32 +: 32]};
    endfunction

    function automatic logic [47:0] in_pl(input int i);
        return {fu_rob_id[i*5 +: 5], fu_pd[i*6 +: 6], fu_rd[i*5 +: 5], fu_data[i*32 +: 32]};
    endfunction

    task automatic set_fu(input int i, input logic [47:0] p);
        fu_rob_id[i*5 +: 5]  = p[47:43];
        fu_pd[i*6 +: 6]      = p[42:37];
        fu_rd[i*5 +: 5]      = p[36:32];
        fu_data[i*32 +: 32]  = p[31:0];
    endtask

    // Scoreboard monitor: pop on broadcast, check ready against queue depth,
    // then push this cycle's accepted results (or clear on reset/flush).
    logic [47:0] m_p;
    bit          m_found;
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < CW; k++) begin
                if (cdb_valid[k] === 1'b1) begin
                    m_p = lane_pl(k);
                    m_found = 1'b0;
                    for (int i = 0; i < NF; i++) begin
                        if (!m_found && sbq[i].size() > 0 && sbq[i][0] === m_p) begin
                            m_found = 1'b1;
                            void'(sbq[i].pop_front());
                            bc_cnt[i]++;
                            if (i == 3) bc_cyc3 = cyc;
                        end
                    end
                    total++;
                    if (!m_found) begin
                        bad++;
                        $display("FAIL sb_match lane%0d got %h, no queue head matches (cyc %0d)", k, m_p, cyc);
                    end
                end
            end
            for (int i = 0; i < NF; i++) begin
                total++;
                if (fu_ready[i] !== (sbq[i].size() != BD)) begin
                    bad++;
                    $display("FAIL ready_fu%0d got %b want %b (cyc %0d)", i, fu_ready[i], sbq[i].size() != BD, cyc);
                end
            end
            if (fu_ready[0] === 1'b0) nr0_seen = 1'b1;
            if (!rst || flush) begin
                for (int i = 0; i < NF; i++) sbq[i].delete();
            end else begin
                for (int i = 0; i < NF; i++)
                    if (fu_valid[i] && fu_ready[i]) sbq[i].push_back(in_pl(i));
            end
        end
    end

    // Present results on the FUs in mask; each holds its item until accepted.
    task automatic stream(input logic [3:0] mask, input int st[NF], input int lim[NF],
                          input int max_cyc, output bit to);
        int done[NF];
        logic [47:0] cur[NF];
        int c;
        bit pend;
        for (int i = 0; i < NF; i++) begin
            done[i] = 0;
            cur[i]  = pl(i, seq);
            seq++;
        end
        c  = 0;
        to = 1'b0;
        while (1) begin
            @(posedge clk); #1;
            pend = 1'b0;
            for (int i = 0; i < NF; i++) begin
                if (mask[i] && done[i] < lim[i]) pend = 1'b1;
                if (mask[i] && done[i] < lim[i] && c >= st[i]) begin
                    fu_valid[i] = 1'b1;
                    set_fu(i, cur[i]);
                end else begin
                    fu_valid[i] = 1'b0;
                end
            end
            if (!pend) break;
            if (c >= max_cyc) begin
                to = 1'b1;
                break;
            end
            @(negedge clk); #1;
            for (int i = 0; i < NF; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    done[i]++;
                    acc_cyc[i] = cyc;
                    cur[i] = pl(i, seq);
                    seq++;
                end
            end
            c++;
        end
        fu_valid = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got %b want 00", cdb_valid); end
        total++; if ({cdb_rob_id, cdb_pd, cdb_rd, cdb_data} !== '0) begin bad++; $display("FAIL reset_payload got %h want 0", {cdb_rob_id, cdb_pd, cdb_rd, cdb_data}); end
        total++; if (fu_ready !== 4'b1111) begin bad++; $display("FAIL reset_ready got %b want 1111", fu_ready); end
    endtask

    task automatic test_single();
        logic [47:0] e;
        e = {5'd3, 6'd9, 5'd7, 32'hDEADBEEF};
        @(posedge clk); #1;
        fu_valid = 4'b0100;
        set_fu(2, e);
        @(posedge clk); #1;
        fu_valid = '0;
        @(negedge clk);
        total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL single_early got %b want 00", cdb_valid); end
        @(negedge clk);
        total++; if (cdb_valid !== 2'b01) begin bad++; $display("FAIL single_valid got %b want 01", cdb_valid); end
        total++; if (lane_pl(0) !== e) begin bad++; $display("FAIL single_payload got %h want %h", lane_pl(0), e); end
        @(negedge clk);
        total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL single_after got %b want 00", cdb_valid); end
    endtask

    // All four FUs fire once; o0..o3 give the required broadcast FU order.
    task automatic test_contention(input string nm, input int o0, input int o1, input int o2, input int o3);
        logic [47:0] e[NF];
        @(posedge clk); #1;
        for (int i = 0; i < NF; i++) begin
            e[i] = pl(i, seq + i);
            set_fu(i, e[i]);
        end
        seq += NF;
        fu_valid = 4'b1111;
        @(posedge clk); #1;
        fu_valid = '0;
        @(negedge clk);
        total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL %s_c1 got %b want 00", nm, cdb_valid); end
        @(negedge clk);
        total++; if (cdb_valid !== 2'b11) begin bad++; $display("FAIL %s_c2_valid got %b want 11", nm, cdb_valid); end
        total++; if (lane_pl(0) !== e[o0]) begin bad++; $display("FAIL %s_c2_lane0 got %h want %h", nm, lane_pl(0), e[o0]); end
        total++; if (lane_pl(1) !== e[o1]) begin bad++; $display("FAIL %s_c2_lane1 got %h want %h", nm, lane_pl(1), e[o1]); end
        @(negedge clk);
        total++; if (cdb_valid !== 2'b11) begin bad++; $display("FAIL %s_c3_valid got %b want 11", nm, cdb_valid); end
        total++; if (lane_pl(0) !== e[o2]) begin bad++; $display("FAIL %s_c3_lane0 got %h want %h", nm, lane_pl(0), e[o2]); end
        total++; if (lane_pl(1) !== e[o3]) begin bad++; $display("FAIL %s_c3_lane1 got %h want %h", nm, lane_pl(1), e[o3]); end
        @(negedge clk);
        total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL %s_c4 got %b want 00", nm, cdb_valid); end
        total++; if (fu_ready !== 4'b1111) begin bad++; $display("FAIL %s_ready got %b want 1111", nm, fu_ready); end
    endtask

    task automatic test_flush();
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) set_fu(i, pl(i, seq + i));
            seq += 3;
            fu_valid = 4'b0111;
        end
        @(posedge clk); #1;
        flush = 1'b1;
        fu_valid = 4'b0010;
        set_fu(1, pl(1, seq));
        seq++;
        @(posedge clk); #1;
        flush = 1'b0;
        fu_valid = '0;
        @(negedge clk);
        total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL flush_valid got %b want 00", cdb_valid); end
        total++; if (fu_ready !== 4'b1111) begin bad++; $display("FAIL flush_ready got %b want 1111", fu_ready); end
        repeat (4) begin
            @(negedge clk);
            total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL flush_quiet got %b want 00", cdb_valid); end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        for (int i = 0; i < NF; i++) set_fu(i, pl(i, seq + i));
        seq += NF;
        fu_valid = 4'b1111;
        @(posedge clk); #1;
        fu_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (cdb_valid !== 2'b11) begin bad++; $display("FAIL rstmid_traffic got %b want 11", cdb_valid); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL rstmid_valid got %b want 00", cdb_valid); end
        total++; if ({cdb_rob_id, cdb_pd, cdb_rd, cdb_data} !== '0) begin bad++; $display("FAIL rstmid_payload got %h want 0", {cdb_rob_id, cdb_pd, cdb_rd, cdb_data}); end
        total++; if (fu_ready !== 4'b1111) begin bad++; $display("FAIL rstmid_ready got %b want 1111", fu_ready); end
        repeat (3) begin
            @(negedge clk);
            total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL rstmid_quiet got %b want 00", cdb_valid); end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int b[NF];
        for (int i = 0; i < NF; i++) b[i] = bc_cnt[i];
        nr0_seen = 1'b0;
        stream(4'b1111, '{0, 0, 0, 0}, '{100, 100, 100, 100}, 1000, to);
        repeat (6) @(negedge clk);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL bp_timeout got %b want 0", to); end
        total++; if (nr0_seen !== 1'b1) begin bad++; $display("FAIL bp_ready0_drop got %b want 1", nr0_seen); end
        for (int i = 0; i < NF; i++) begin
            total++; if (bc_cnt[i] - b[i] != 100) begin bad++; $display("FAIL bp_count_fu%0d got %0d want 100", i, bc_cnt[i] - b[i]); end
            total++; if (sbq[i].size() != 0) begin bad++; $display("FAIL bp_drain_fu%0d got %0d want 0", i, sbq[i].size()); end
        end
    endtask

    task automatic test_fairness();
        bit to;
        int b0, d;
        b0 = bc_cnt[0];
        bc_cyc3 = -1;
        stream(4'b1111, '{0, 0, 0, 10}, '{40, 40, 40, 1}, 500, to);
        repeat (6) @(negedge clk);
        d = bc_cyc3 - acc_cyc[3];
        total++; if (to !== 1'b0) begin bad++; $display("FAIL fair_timeout got %b want 0", to); end
        total++; if (d < 2 || d > 3) begin bad++; $display("FAIL fair_fu3_latency got %0d want 2..3", d); end
        total++; if (bc_cnt[0] - b0 != 40) begin bad++; $display("FAIL fair_fu0_count got %0d want 40", bc_cnt[0] - b0); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; fu_valid = '0;
        fu_rob_id = '0; fu_pd = '0; fu_rd = '0; fu_data = '0;
        test_reset();
        test_single();
        test_contention("cont_p3", 3, 0, 1, 2);
        test_flush();
        test_contention("cont_p0", 0, 1, 2, 3);
        test_single();
        test_reset_mid();
        test_contention("cont_rst", 0, 1, 2, 3);
        test_backpressure();
        test_fairness();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
